// File: rtl/spi_slave_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// spi_slave_pkg: shared pad-mode, bit-count and tx-sequencer state encodings.
// Revision: 1.0
// ============================================================================
package spi_slave_pkg;

    localparam logic [1:0] SPI_STD_TX  = 2'b00;
    localparam logic [1:0] SPI_STD_RX  = 2'b01;
    localparam logic [1:0] SPI_QUAD_TX = 2'b10;
    localparam logic [1:0] SPI_QUAD_RX = 2'b11;

    localparam logic [7:0] BITS_STD_M1  = 8'd31;
    localparam logic [7:0] BITS_QUAD_M1 = 8'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DUMMY = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_SHIFT = 2'd3;

    typedef enum logic [1:0] {
        TXS_IDLE  = ST_IDLE,
        TXS_DUMMY = ST_DUMMY,
        TXS_LOAD  = ST_LOAD,
        TXS_SHIFT = ST_SHIFT
    } tx_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_tx_prefetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// spi_slave_tx_prefetch: one-entry read-stream buffer with per-burst fetch cap.
// Revision: 1.0
// ============================================================================
module spi_slave_tx_prefetch
    import spi_slave_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             active_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      rd_data_i,
    input  logic             rd_valid_i,
    output logic             rd_ready_o,
    input  logic             consume_i,
    output logic             buf_valid_o,
    output logic [31:0]      buf_data_o
);

    logic             buf_valid_q, buf_valid_d;
    logic [31:0]      buf_data_q, buf_data_d;
    logic [LEN_W-1:0] fetched_q, fetched_d;
    logic             w_fill;

    assign rd_ready_o  = active_i & ~buf_valid_q & (fetched_q < len_i);
    assign w_fill      = rd_valid_i & rd_ready_o;
    assign buf_valid_o = buf_valid_q;
    assign buf_data_o  = buf_data_q;

    // A fill only happens into an empty buffer, so a consume of the same
    // cycle never refers to the incoming word: that word is kept for later.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        fetched_d   = fetched_q;
        if (clear_i) begin
            buf_valid_d = 1'b0;
            fetched_d   = '0;
        end else if (w_fill) begin
            buf_valid_d = 1'b1;
            buf_data_d  = rd_data_i;
            fetched_d   = fetched_q + LEN_W'(1);
        end else if (consume_i) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            fetched_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            fetched_q   <= fetched_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_tx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// spi_slave_tx_ctrl: SPI slave tx sequencer (dummy wait, word load, shift).
// Revision: 1.0
// ============================================================================
module spi_slave_tx_ctrl
    import spi_slave_pkg::*;
#(
    parameter int          LEN_W        = 16,
    parameter int          DUMMY_W      = 5,
    parameter logic [31:0] FILL_PATTERN = 32'hDEAD_BEEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               quad_i,
    input  logic [DUMMY_W-1:0] dummy_i,
    input  logic               abort_i,
    input  logic [31:0]        rd_data_i,
    input  logic               rd_valid_i,
    output logic               rd_ready_o,
    output logic [31:0]        tx_data_o,
    output logic               tx_data_valid_o,
    output logic [7:0]         tx_counter_o,
    output logic               tx_counter_upd_o,
    output logic               tx_en_quad_o,
    input  logic               tx_done_i,
    output logic [1:0]         pad_mode_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               underflow_o
);

    logic [1:0]         state_q, state_d;
    logic [LEN_W-1:0]   words_left_q, words_left_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               quad_q, quad_d;
    logic [DUMMY_W-1:0] dummy_cnt_q, dummy_cnt_d;
    logic               underflow_q, underflow_d;
    logic               done_q, done_d;

    logic               w_busy;
    logic               w_tx_phase;
    logic               w_last;
    logic               w_load;
    logic               w_buf_valid;
    logic [31:0]        w_buf_data;

    assign w_busy     = (state_q != ST_IDLE);
    assign w_tx_phase = (state_q == ST_LOAD) | (state_q == ST_SHIFT);
    assign w_last     = (words_left_q == '0);
    // Load strobe is combinational on tx_done_i so back-to-back words have no gap.
    assign w_load     = ~abort_i & ((state_q == ST_LOAD) |
                                    ((state_q == ST_SHIFT) & tx_done_i & ~w_last));

    spi_slave_tx_prefetch #(
        .LEN_W (LEN_W)
    ) u_prefetch (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (abort_i | ~w_busy),
        .active_i    (w_busy),
        .len_i       (len_q),
        .rd_data_i   (rd_data_i),
        .rd_valid_i  (rd_valid_i),
        .rd_ready_o  (rd_ready_o),
        .consume_i   (w_load),
        .buf_valid_o (w_buf_valid),
        .buf_data_o  (w_buf_data)
    );

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        len_d        = len_q;
        quad_d       = quad_q;
        dummy_cnt_d  = dummy_cnt_q;
        underflow_d  = underflow_q;
        done_d       = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        underflow_d = 1'b0;
                        if (len_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            len_d        = len_i;
                            words_left_d = len_i;
                            quad_d       = quad_i;
                            dummy_cnt_d  = dummy_i;
                            state_d      = (dummy_i != '0) ? ST_DUMMY : ST_LOAD;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (dummy_cnt_q == DUMMY_W'(1)) begin
                        state_d = ST_LOAD;
                    end else begin
                        dummy_cnt_d = dummy_cnt_q - DUMMY_W'(1);
                    end
                end
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tx_done_i && w_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (w_load) begin
            words_left_d = words_left_q - LEN_W'(1);
            if (!w_buf_valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            words_left_q <= '0;
            len_q        <= '0;
            quad_q       <= 1'b0;
            dummy_cnt_q  <= '0;
            underflow_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            len_q        <= len_d;
            quad_q       <= quad_d;
            dummy_cnt_q  <= dummy_cnt_d;
            underflow_q  <= underflow_d;
            done_q       <= done_d;
        end
    end

    assign tx_data_valid_o  = w_load;
    assign tx_counter_upd_o = w_load;
    assign tx_data_o        = w_load ? (w_buf_valid ? w_buf_data : FILL_PATTERN) : 32'h0;
    assign tx_counter_o     = quad_q ? BITS_QUAD_M1 : BITS_STD_M1;
    assign tx_en_quad_o     = w_busy & quad_q;
    assign pad_mode_o       = w_tx_phase ? (quad_q ? SPI_QUAD_TX : SPI_STD_TX) : SPI_STD_RX;
    assign busy_o           = w_busy;
    assign done_o           = done_q;
    assign underflow_o      = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_tx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_spi_slave_tx_ctrl: scoreboard bench for the SPI slave tx sequencer.
// Revision: 1.0
// ============================================================================
module tb_spi_slave_tx_ctrl;

    localparam logic [31:0] FILL = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] len_i = '0;
    logic        quad_i = 1'b0;
    logic [4:0]  dummy_i = '0;
    logic        abort_i = 1'b0;
    logic [31:0] rd_data_i = '0;
    logic        rd_valid_i = 1'b0;
    logic        rd_ready_o;
    logic [31:0] tx_data_o;
    logic        tx_data_valid_o;
    logic [7:0]  tx_counter_o;
    logic        tx_counter_upd_o;
    logic        tx_en_quad_o;
    logic        tx_done_i = 1'b0;
    logic [1:0]  pad_mode_o;
    logic        busy_o;
    logic        done_o;
    logic        underflow_o;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    logic [7:0]  exp_bits = 8'd31;
    logic [31:0] exp_q[$];
    logic [31:0] src_q[$];

    always #5 clk_i = ~clk_i;

    spi_slave_tx_ctrl dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .len_i            (len_i),
        .quad_i           (quad_i),
        .dummy_i          (dummy_i),
        .abort_i          (abort_i),
        .rd_data_i        (rd_data_i),
        .rd_valid_i       (rd_valid_i),
        .rd_ready_o       (rd_ready_o),
        .tx_data_o        (tx_data_o),
        .tx_data_valid_o  (tx_data_valid_o),
        .tx_counter_o     (tx_counter_o),
        .tx_counter_upd_o (tx_counter_upd_o),
        .tx_en_quad_o     (tx_en_quad_o),
        .tx_done_i        (tx_done_i),
        .pad_mode_o       (pad_mode_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .underflow_o      (underflow_o)
    );

    task automatic src_refresh();
        rd_valid_i = (src_q.size() > 0);
        rd_data_i  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    endtask

    // Mid-cycle sample: scoreboard every load strobe, track stream handshakes.
    task automatic sample();
        logic [31:0] exp;
        @(negedge clk_i);
        if (tx_data_valid_o === 1'b1) begin
            load_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: got data %h, required no load", tx_data_o);
            end else begin
                exp = exp_q.pop_front();
                if (tx_data_o !== exp) begin
                    errors++;
                    $display("FAIL load_data: got %h, required %h", tx_data_o, exp);
                end
            end
            checks++;
            if ({tx_counter_upd_o, tx_counter_o} !== {1'b1, exp_bits}) begin
                errors++;
                $display("FAIL load_counter: got upd=%b cnt=%0d, required upd=1 cnt=%0d",
                         tx_counter_upd_o, tx_counter_o, exp_bits);
            end
        end
        if (done_o === 1'b1) done_cnt++;
        if (rd_valid_i && rd_ready_o === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
        src_refresh();
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic new_burst(input int len, input logic q, input int dmy);
        exp_q.delete();
        load_cnt = 0;
        done_cnt = 0;
        exp_bits = q ? 8'd7 : 8'd31;
        start_i = 1'b1;
        len_i   = 16'(len);
        quad_i  = q;
        dummy_i = 5'(dmy);
    endtask

    // Emulated shifter: gap busy cycles, then one tx_done_i cycle.
    task automatic run_word(input int gap, input logic [1:0] pad, output logic strobe);
        for (int i = 0; i < gap; i++) begin
            sample();
            checks++;
            if (pad_mode_o !== pad || tx_data_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL shift_gap: got pad=%b valid=%b, required pad=%b valid=0",
                         pad_mode_o, tx_data_valid_o, pad);
            end
            advance();
        end
        tx_done_i = 1'b1;
        sample();
        strobe = tx_data_valid_o;
        advance();
        tx_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({rd_ready_o, tx_data_valid_o, tx_counter_upd_o, tx_data_o, tx_counter_o,
             tx_en_quad_o, pad_mode_o, busy_o, done_o, underflow_o}
            !== {3'b000, 32'h0, 8'd31, 1'b0, 2'b01, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got data=%h cnt=%0d pad=%b flags=%b",
                     tx_data_o, tx_counter_o, pad_mode_o,
                     {rd_ready_o, tx_data_valid_o, tx_counter_upd_o, tx_en_quad_o,
                      busy_o, done_o, underflow_o});
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cyc(2);
    endtask

    task automatic test_std_burst();
        logic s;
        src_q = {32'hA5A5_A5A5, 32'h1234_5678};
        src_refresh();
        new_burst(2, 1'b0, 0);
        // No dummy cycles: the buffer is still empty at LOAD, so the first word
        // is the fill pattern and the word arriving that cycle is sent second.
        exp_q = {FILL, 32'hA5A5_A5A5};
        sample();
        checks++;
        if ({busy_o, pad_mode_o} !== {1'b0, 2'b01}) begin
            errors++;
            $display("FAIL std_idle: got busy=%b pad=%b, required busy=0 pad=01", busy_o, pad_mode_o);
        end
        advance();
        start_i = 1'b0;
        sample();
        checks++;
        if ({tx_data_valid_o, tx_counter_o, pad_mode_o, busy_o} !== {1'b1, 8'd31, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL std_first_load: got valid=%b cnt=%0d pad=%b busy=%b, required 1/31/00/1",
                     tx_data_valid_o, tx_counter_o, pad_mode_o, busy_o);
        end
        advance();
        run_word(3, 2'b00, s);
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL std_second_load: got strobe=%b at first done, required 1", s);
        end
        run_word(3, 2'b00, s);
        checks++;
        if (s !== 1'b0) begin
            errors++;
            $display("FAIL std_last_done: got strobe=%b at last done, required 0", s);
        end
        sample();
        checks++;
        if ({done_o, busy_o, pad_mode_o} !== {1'b1, 1'b0, 2'b01}) begin
            errors++;
            $display("FAIL std_done: got done=%b busy=%b pad=%b, required 1/0/01", done_o, busy_o, pad_mode_o);
        end
        advance();
        cyc(2);
        checks++;
        if (load_cnt != 2 || done_cnt != 1 || exp_q.size() != 0 || underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL std_totals: got loads=%0d dones=%0d pending=%0d uf=%b, required 2/1/0/1",
                     load_cnt, done_cnt, exp_q.size(), underflow_o);
        end
    endtask

    task automatic test_quad_burst();
        logic s;
        src_q = {32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        src_refresh();
        new_burst(3, 1'b1, 4);
        exp_q = {32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        sample();
        advance();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            checks++;
            if ({tx_data_valid_o, pad_mode_o, busy_o} !== {1'b0, 2'b01, 1'b1}) begin
                errors++;
                $display("FAIL quad_dummy%0d: got valid=%b pad=%b busy=%b, required 0/01/1",
                         i, tx_data_valid_o, pad_mode_o, busy_o);
            end
            advance();
        end
        sample();
        checks++;
        if ({tx_data_valid_o, tx_counter_o, tx_en_quad_o, pad_mode_o} !== {1'b1, 8'd7, 1'b1, 2'b10}) begin
            errors++;
            $display("FAIL quad_load: got valid=%b cnt=%0d quad=%b pad=%b, required 1/7/1/10",
                     tx_data_valid_o, tx_counter_o, tx_en_quad_o, pad_mode_o);
        end
        advance();
        run_word(3, 2'b10, s);
        run_word(3, 2'b10, s);
        run_word(3, 2'b10, s);
        cyc(3);
        checks++;
        if (load_cnt != 3 || done_cnt != 1 || exp_q.size() != 0 || underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL quad_totals: got loads=%0d dones=%0d pending=%0d uf=%b, required 3/1/0/0",
                     load_cnt, done_cnt, exp_q.size(), underflow_o);
        end
    endtask

    task automatic test_underflow();
        logic s;
        src_q = {32'hCAFE_F00D};
        src_refresh();
        new_burst(2, 1'b0, 2);
        exp_q = {32'hCAFE_F00D, FILL};
        sample();
        advance();
        start_i = 1'b0;
        cyc(3);
        checks++;
        if (underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL uf_early: got underflow=%b after first load, required 0", underflow_o);
        end
        run_word(2, 2'b00, s);
        sample();
        checks++;
        if (underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL uf_set: got underflow=%b after fill load, required 1", underflow_o);
        end
        advance();
        run_word(2, 2'b00, s);
        cyc(3);
        checks++;
        if (underflow_o !== 1'b1 || load_cnt != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL uf_sticky: got uf=%b loads=%0d pending=%0d, required 1/2/0",
                     underflow_o, load_cnt, exp_q.size());
        end
        new_burst(0, 1'b0, 0);
        sample();
        advance();
        start_i = 1'b0;
        sample();
        checks++;
        if (underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL uf_clear: got underflow=%b after start, required 0", underflow_o);
        end
        advance();
        cyc(2);
    endtask

    task automatic test_abort();
        logic s;
        src_q = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        src_refresh();
        new_burst(4, 1'b0, 1);
        exp_q = {32'h1111_1111, 32'h2222_2222};
        sample();
        advance();
        start_i = 1'b0;
        cyc(2);
        run_word(2, 2'b00, s);
        cyc(1);
        abort_i = 1'b1;
        sample();
        advance();
        abort_i = 1'b0;
        sample();
        checks++;
        if ({busy_o, rd_ready_o, tx_data_valid_o, pad_mode_o} !== {3'b000, 2'b01}) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b ready=%b valid=%b pad=%b, required 0/0/0/01",
                     busy_o, rd_ready_o, tx_data_valid_o, pad_mode_o);
        end
        advance();
        cyc(3);
        checks++;
        if (done_cnt != 0 || load_cnt != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_totals: got dones=%0d loads=%0d pending=%0d, required 0/2/0",
                     done_cnt, load_cnt, exp_q.size());
        end
        src_q = {32'h5555_5555, 32'h6666_6666};
        src_refresh();
        new_burst(2, 1'b0, 1);
        exp_q = {32'h5555_5555, 32'h6666_6666};
        sample();
        advance();
        start_i = 1'b0;
        cyc(3);
        run_word(2, 2'b00, s);
        run_word(2, 2'b00, s);
        cyc(2);
        checks++;
        if (done_cnt != 1 || load_cnt != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_recover: got dones=%0d loads=%0d pending=%0d, required 1/2/0",
                     done_cnt, load_cnt, exp_q.size());
        end
    endtask

    task automatic test_len_zero_and_busy_start();
        logic s;
        src_q.delete();
        src_refresh();
        new_burst(0, 1'b0, 0);
        sample();
        advance();
        start_i = 1'b0;
        sample();
        checks++;
        if ({done_o, tx_data_valid_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL len0_done: got done=%b valid=%b busy=%b, required 1/0/0",
                     done_o, tx_data_valid_o, busy_o);
        end
        advance();
        cyc(2);
        checks++;
        if (done_cnt != 1 || load_cnt != 0) begin
            errors++;
            $display("FAIL len0_totals: got dones=%0d loads=%0d, required 1/0", done_cnt, load_cnt);
        end
        src_q = {32'hABCD_0001, 32'hABCD_0002};
        src_refresh();
        new_burst(2, 1'b0, 3);
        exp_q = {32'hABCD_0001, 32'hABCD_0002};
        sample();
        advance();
        start_i = 1'b1;
        len_i   = 16'd5;
        quad_i  = 1'b1;
        dummy_i = 5'd0;
        sample();
        checks++;
        if ({busy_o, pad_mode_o, tx_en_quad_o, tx_data_valid_o} !== {1'b1, 2'b01, 2'b00}) begin
            errors++;
            $display("FAIL busy_start: got busy=%b pad=%b quad=%b valid=%b, required 1/01/0/0",
                     busy_o, pad_mode_o, tx_en_quad_o, tx_data_valid_o);
        end
        advance();
        start_i = 1'b0;
        cyc(2);
        sample();
        checks++;
        if ({tx_data_valid_o, tx_en_quad_o} !== 2'b10) begin
            errors++;
            $display("FAIL busy_load: got valid=%b quad=%b, required 1/0", tx_data_valid_o, tx_en_quad_o);
        end
        advance();
        run_word(2, 2'b00, s);
        run_word(2, 2'b00, s);
        cyc(3);
        checks++;
        if (load_cnt != 2 || done_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL busy_totals: got loads=%0d dones=%0d pending=%0d, required 2/1/0",
                     load_cnt, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic s;
        src_q = {32'h7777_0001, 32'h7777_0002, 32'h7777_0003};
        src_refresh();
        new_burst(3, 1'b1, 1);
        exp_q = {32'h7777_0001};
        sample();
        advance();
        start_i = 1'b0;
        cyc(3);
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({rd_ready_o, tx_data_valid_o, tx_counter_upd_o, tx_data_o, tx_counter_o,
             tx_en_quad_o, pad_mode_o, busy_o, done_o, underflow_o}
            !== {3'b000, 32'h0, 8'd31, 1'b0, 2'b01, 3'b000}) begin
            errors++;
            $display("FAIL reset_async: got data=%h cnt=%0d pad=%b flags=%b",
                     tx_data_o, tx_counter_o, pad_mode_o,
                     {rd_ready_o, tx_data_valid_o, tx_counter_upd_o, tx_en_quad_o,
                      busy_o, done_o, underflow_o});
        end
        checks++;
        if (load_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_preload: got loads=%0d pending=%0d, required 1/0", load_cnt, exp_q.size());
        end
        src_q.delete();
        src_refresh();
        advance();
        advance();
        rst_ni = 1'b1;
        cyc(1);
        src_q = {32'h8888_0001};
        src_refresh();
        new_burst(1, 1'b0, 1);
        exp_q = {32'h8888_0001};
        sample();
        advance();
        start_i = 1'b0;
        cyc(2);
        run_word(2, 2'b00, s);
        sample();
        checks++;
        if ({done_o, load_cnt == 1, exp_q.size() == 0} !== 3'b111) begin
            errors++;
            $display("FAIL reset_recover: got done=%b loads=%0d pending=%0d, required 1/1/0",
                     done_o, load_cnt, exp_q.size());
        end
        advance();
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_std_burst();
        test_quad_burst();
        test_underflow();
        test_abort();
        test_len_zero_and_busy_start();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
